// File: rtl/branch_resolve_stage_if.sv
// Handshake bundle between ALU stage, branch resolve stage and memory stage.
// Trap signals exist only when BR_MISALIGN_TRAP_EN is defined.
interface branch_resolve_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] aluresult;
    logic [3:0]      flags;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memwrite;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_regwrite;
    logic            out_memwrite;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
`ifdef BR_MISALIGN_TRAP_EN
    logic            trap;
    logic [XLEN-1:0] trap_pc;
`endif

    modport master (
        output in_valid, aluresult, flags, pc, imm, funct3,
        output branch, jal, jalr, rd, regwrite, memwrite, out_ready,
        input  in_ready, out_valid, out_result, out_rd,
        input  out_regwrite, out_memwrite,
`ifdef BR_MISALIGN_TRAP_EN
        input  trap, trap_pc,
`endif
        input  redirect, redirect_pc
    );

    modport slave (
        input  in_valid, aluresult, flags, pc, imm, funct3,
        input  branch, jal, jalr, rd, regwrite, memwrite, out_ready,
        output in_ready, out_valid, out_result, out_rd,
        output out_regwrite, out_memwrite,
`ifdef BR_MISALIGN_TRAP_EN
        output trap, trap_pc,
`endif
        output redirect, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: RV32I condition/target, redirect + squash, 2-entry skid buffer.
// Define BR_MISALIGN_TRAP_EN to trap on taken targets with bit 1 set.
module branch_resolve_stage #(
    parameter int XLEN          = 32,
    parameter int SQUASH_CYCLES = 1
) (
    input logic                   clk,
    input logic                   reset,
    branch_resolve_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
    } ent_t;

    logic [1:0]      cnt_q, cnt_d;
    ent_t            head_q, head_d;
    ent_t            tail_q, tail_d;
    logic            in_ready_q, in_ready_d;
    logic [1:0]      sq_q, sq_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
`ifdef BR_MISALIGN_TRAP_EN
    logic            trap_q, trap_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
`endif

    logic            accept;
    logic            live;
    logic            cond;
    logic            taken;
    logic            misalign;
    logic            push;
    logic            pop;
    logic            out_valid;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    ent_t            new_ent;

    // flags are packed {v,c,n,z}
    always_comb begin
        cond = 1'b0;
        unique case (bus.funct3)
            3'b000:  cond = bus.flags[0];
            3'b001:  cond = ~bus.flags[0];
            3'b100:  cond = bus.flags[1] ^ bus.flags[3];
            3'b101:  cond = ~(bus.flags[1] ^ bus.flags[3]);
            3'b110:  cond = ~bus.flags[2];
            3'b111:  cond = bus.flags[2];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        accept = bus.in_valid & in_ready_q;
        live   = accept & (sq_q == 2'd0);
        taken  = (bus.branch & cond) | bus.jal | bus.jalr;
        target = bus.jalr ? {bus.aluresult[XLEN-1:1], 1'b0}
                          : bus.pc + bus.imm;
        link   = bus.pc + XLEN'(4);
`ifdef BR_MISALIGN_TRAP_EN
        misalign = taken & target[1];
`else
        misalign = 1'b0;
`endif
        new_ent.result   = (bus.jal | bus.jalr) ? link : bus.aluresult;
        new_ent.rd       = bus.rd;
        new_ent.regwrite = bus.regwrite & ~misalign;
        new_ent.memwrite = bus.memwrite;
    end

    // Squash window counts cycles, not beats, starting the cycle after a taken beat
    always_comb begin
        sq_d          = sq_q;
        redirect_d    = live & taken & ~misalign;
        redirect_pc_d = redirect_pc_q;
        if (live & taken) begin
            sq_d          = 2'(SQUASH_CYCLES);
            redirect_pc_d = target;
        end else if (sq_q != 2'd0) begin
            sq_d = sq_q - 2'd1;
        end
    end

`ifdef BR_MISALIGN_TRAP_EN
    always_comb begin
        trap_d    = live & misalign;
        trap_pc_d = trap_d ? bus.pc : trap_pc_q;
    end
`endif

    assign out_valid = (cnt_q != 2'd0);
    assign push      = live;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = new_ent;
                else tail_d = new_ent;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = new_ent;
                end else begin
                    head_d = tail_q;
                    tail_d = new_ent;
                end
            end
            default: ;
        endcase
        in_ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            in_ready_q    <= 1'b1;
            sq_q          <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
`ifdef BR_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
            trap_pc_q     <= '0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            in_ready_q    <= in_ready_d;
            sq_q          <= sq_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
`ifdef BR_MISALIGN_TRAP_EN
            trap_q        <= trap_d;
            trap_pc_q     <= trap_pc_d;
`endif
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid;
    assign bus.out_result   = head_q.result;
    assign bus.out_rd       = head_q.rd;
    assign bus.out_regwrite = head_q.regwrite;
    assign bus.out_memwrite = head_q.memwrite;
    assign bus.redirect     = redirect_q;
    assign bus.redirect_pc  = redirect_pc_q;
`ifdef BR_MISALIGN_TRAP_EN
    assign bus.trap         = trap_q;
    assign bus.trap_pc      = trap_pc_q;
`endif
endmodule

// File: tb/tb_branch_resolve_stage.sv
// Scoreboard bench for branch_resolve_stage: directed cases then random traffic.
// Honours BR_MISALIGN_TRAP_EN when defined.
module tb_branch_resolve_stage;
    localparam int XLEN = 32;
    localparam int SQ   = 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   or_mode = 1;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          last_ctrl = -100;
    int          redir_cyc = -1;
    logic [31:0] redir_pc_e = '0;
    bit          exp_trap = 0;
    bit          prev_rst = 1;
    bit          held = 0;
    logic [31:0] h_res;
    logic [4:0]  h_rd;
    logic        h_rw, h_mw;

    branch_resolve_stage_if #(.XLEN(XLEN)) bus();

    branch_resolve_stage #(.XLEN(XLEN), .SQUASH_CYCLES(SQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference rules: condition from {v,c,n,z}
    function automatic bit br_cond(input logic [2:0] f3, input logic [3:0] fl);
        bit v, c, n, z;
        v = fl[3]; c = fl[2]; n = fl[1]; z = fl[0];
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return !c;
            3'd7: return c;
            default: return 0;
        endcase
    endfunction

    // Monitor + model
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (prev_rst) begin
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_in_ready", 32'(bus.in_ready), 1);
                chk("rst_redirect", 32'(bus.redirect), 0);
                chk("rst_redirect_pc", bus.redirect_pc, 0);
                chk("rst_out_result", bus.out_result, 0);
                chk("rst_out_rd", 32'(bus.out_rd), 0);
                chk("rst_out_rw", 32'(bus.out_regwrite), 0);
                chk("rst_out_mw", 32'(bus.out_memwrite), 0);
`ifdef BR_MISALIGN_TRAP_EN
                chk("rst_trap", 32'(bus.trap), 0);
                chk("rst_trap_pc", bus.trap_pc, 0);
`endif
            end
            exp_q.delete();
            redir_cyc = -1;
            last_ctrl = -100;
            held = 0;
        end else begin
            chk("redirect", 32'(bus.redirect),
                32'((redir_cyc == cyc) && !exp_trap));
            if (redir_cyc == cyc && !exp_trap)
                chk("redirect_pc", bus.redirect_pc, redir_pc_e);
`ifdef BR_MISALIGN_TRAP_EN
            chk("trap", 32'(bus.trap), 32'((redir_cyc == cyc) && exp_trap));
            if (redir_cyc == cyc && exp_trap)
                chk("trap_pc", bus.trap_pc, redir_pc_e);
`endif
            if (held) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_result", bus.out_result, h_res);
                chk("hold_rd", 32'(bus.out_rd), 32'(h_rd));
                chk("hold_rw", 32'(bus.out_regwrite), 32'(h_rw));
                chk("hold_mw", 32'(bus.out_memwrite), 32'(h_mw));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", bus.out_result, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_result", bus.out_result, e.res);
                    chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
                    chk("out_regwrite", 32'(bus.out_regwrite), 32'(e.rw));
                    chk("out_memwrite", 32'(bus.out_memwrite), 32'(e.mw));
                end
            end
            held  = bus.out_valid && !bus.out_ready;
            h_res = bus.out_result;
            h_rd  = bus.out_rd;
            h_rw  = bus.out_regwrite;
            h_mw  = bus.out_memwrite;
            if (bus.in_valid && bus.in_ready) begin
                int d;
                d = cyc - last_ctrl;
                if (!(d >= 1 && d <= SQ)) begin
                    exp_t e;
                    bit tk, mis;
                    logic [31:0] tgt;
                    tk = bus.jal || bus.jalr ||
                         (bus.branch && br_cond(bus.funct3, bus.flags));
                    tgt = bus.jalr ? (bus.aluresult & ~32'h1)
                                   : bus.pc + bus.imm;
                    mis = 0;
`ifdef BR_MISALIGN_TRAP_EN
                    mis = tk && tgt[1];
`endif
                    e.res = (bus.jal || bus.jalr) ? bus.pc + 32'd4 : bus.aluresult;
                    e.rd  = bus.rd;
                    e.rw  = bus.regwrite && !mis;
                    e.mw  = bus.memwrite;
                    exp_q.push_back(e);
                    if (tk) begin
                        last_ctrl  = cyc;
                        redir_cyc  = cyc + 1;
                        exp_trap   = mis;
                        redir_pc_e = mis ? bus.pc : tgt;
                    end
                end
            end
        end
        prev_rst = reset;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (or_mode == 2) bus.out_ready = ($urandom % 4) != 0;
            else if (or_mode == 1) bus.out_ready = 1'b1;
            else bus.out_ready = 1'b0;
        end
    end

    task automatic send(input logic [31:0] alu, input logic [31:0] pc_,
                        input logic [31:0] imm_, input logic [3:0] fl,
                        input logic [2:0] f3, input int kind,
                        input logic [4:0] rd_, input logic rw,
                        input logic mw);
        bit acc;
        int n;
        bus.aluresult = alu;
        bus.pc        = pc_;
        bus.imm       = imm_;
        bus.flags     = fl;
        bus.funct3    = f3;
        bus.branch    = (kind == 1);
        bus.jal       = (kind == 2);
        bus.jalr      = (kind == 3);
        bus.rd        = rd_;
        bus.regwrite  = rw;
        bus.memwrite  = mw;
        bus.in_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'(n), 0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic plain(input logic [31:0] alu, input logic [4:0] rd_);
        send(alu, 32'h200, 32'h0, 4'h0, 3'd0, 0, rd_, 1'b1, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.aluresult = 32'h1111; bus.pc = 32'h10; bus.imm = 32'h4;
        bus.flags = 4'h1; bus.funct3 = 3'd0; bus.branch = 1'b1;
        bus.jal = 1'b0; bus.jalr = 1'b0; bus.rd = 5'd3;
        bus.regwrite = 1'b1; bus.memwrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        plain(32'hA5A5_0001, 5'd1);
        chk("first_latency", 32'(bus.out_valid), 1);
        idle(3);

        send(32'h0, 32'h100, 32'h20, 4'b0001, 3'd0, 1, 5'd0, 1'b0, 1'b0);
        plain(32'hBAD0_0001, 5'd9);
        idle(4);
        send(32'h5, 32'h300, 32'h40, 4'b1010, 3'd4, 1, 5'd0, 1'b0, 1'b0);
        plain(32'h0000_0002, 5'd2);
        idle(2);
        send(32'h6, 32'h400, 32'h80, 4'b0000, 3'd6, 1, 5'd0, 1'b0, 1'b0);
        plain(32'hBAD0_0002, 5'd9);
        idle(3);
        send(32'h7, 32'h500, 32'h10, 4'b1111, 3'd2, 1, 5'd0, 1'b0, 1'b0);
        plain(32'h0000_0003, 5'd3);
        idle(2);
        send(32'h2003, 32'h40, 32'h0, 4'h0, 3'd0, 3, 5'd1, 1'b1, 1'b0);
        idle(3);
        send(32'h0, 32'hFFFF_FFFC, 32'h8, 4'h0, 3'd0, 2, 5'd1, 1'b1, 1'b0);
        idle(3);
        send(32'h0, 32'h100, 32'h2, 4'b0001, 3'd0, 1, 5'd7, 1'b1, 1'b0);
        idle(4);

        #2;
        or_mode = 0;
        bus.out_ready = 1'b0;
        fork
            begin
                plain(32'hC000_0001, 5'd11);
                plain(32'hC000_0002, 5'd12);
                plain(32'hC000_0003, 5'd13);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready_low", 32'(bus.in_ready), 0);
                chk("bp_out_valid", 32'(bus.out_valid), 1);
                @(posedge clk);
                #2;
                or_mode = 1;
                bus.out_ready = 1'b1;
            end
        join
        idle(5);

        #2;
        or_mode = 0;
        bus.out_ready = 1'b0;
        plain(32'hD000_0001, 5'd14);
        send(32'h0, 32'h600, 32'h30, 4'h0, 3'd0, 2, 5'd15, 1'b1, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        or_mode = 1;
        idle(3);

        or_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int k, r;
            r = int'($urandom_range(0, 9));
            k = (r < 5) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            send($urandom, $urandom, $urandom, 4'($urandom), 3'($urandom),
                 k, 5'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        or_mode = 1;
        idle(10);
        chk("drain_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
- Execute-to-memory stage directly downstream of the ALU. Consumes the ALU result and flags {v,c,n,z}, evaluates the RV32I branch condition and computes jump/branch targets.
- Issues a one-cycle PC redirect and squashes the wrong-path beat.
- Forwards surviving instructions to the memory stage through a registered 2-entry skid buffer with valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width of result, pc, imm and target.
- SQUASH_CYCLES, 1, number of cycles after a redirect during which accepted input beats are discarded (legal range 1-3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU stage holds a valid instruction.
- in_ready  out  1  stage can accept; registered, equals skid buffer not full.
- aluresult  in  XLEN  ALU result.
- flags  in  4  ALU flags {v,c,n,z}.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  sign-extended branch/jal offset.
- funct3  in  3  branch type.
- branch  in  1  instruction is a conditional branch.
- jal  in  1  instruction is jal.
- jalr  in  1  instruction is jalr.
- rd  in  5  destination register.
- regwrite  in  1  writes rd.
- memwrite  in  1  store.
- out_valid  out  1  output beat valid.
- out_ready  in  1  memory stage accepts.
- out_result  out  XLEN  aluresult, or pc+4 for jal/jalr.
- out_rd  out  5  forwarded rd.
- out_regwrite  out  1  forwarded regwrite.
- out_memwrite  out  1  forwarded memwrite.
- redirect  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  XLEN  redirect target, valid while redirect=1.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset: out_valid=0, in_ready=1, redirect=0, redirect_pc=0, out_result=0, out_rd=0, out_regwrite=0, out_memwrite=0. Skid buffer emptied, squash counter cleared.
- Reset mid-operation: all buffered beats and any pending redirect are dropped.
- Accept: a beat is accepted when in_valid & in_ready.
- Branch conditions on flags:
  - funct3 000 beq: z
  - 001 bne: ~z
  - 100 blt: n^v
  - 101 bge: ~(n^v)
  - 110 bltu: ~c
  - 111 bgeu: c
  - 010/011: not taken.
- Targets:
  - Branch/jal: pc+imm, modulo 2^XLEN (wraps, no error).
  - jalr: aluresult with bit 0 cleared.
  - jal/jalr: out_result = pc+4 (wraps).
- Taken (branch & cond) | jal | jalr accepted in cycle T:
  - redirect=1 and redirect_pc=target in T+1 only.
  - The instruction itself is still enqueued.
- Squash:
  - Beats accepted during the SQUASH_CYCLES cycles starting at T+1 are consumed (in_ready semantics unchanged) but never enqueued.
  - A taken branch among squashed beats raises no redirect.
- Back-to-back redirects are impossible; a second control-flow beat in the squash window is discarded.
- Skid buffer:
  - 2 entries, in-order.
  - Outputs driven from the head entry register.
  - out_valid & out_ready pops the head.
  - Simultaneous push and pop keeps occupancy constant.
  - in_ready deasserts the cycle after occupancy reaches 2.
  - Zero bubbles at full throughput.
  - Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Output stability: while out_valid & ~out_ready, all out_* are held stable.
- Sequencing: a redirect is never delayed by output backpressure.

Optional Feature:
- Macro BR_MISALIGN_TRAP_EN.
- When defined:
  - Adds output trap (1, reset 0) and trap_pc (XLEN, reset 0).
  - A taken target with bit 1 set suppresses redirect, raises trap=1 for one cycle in T+1 with trap_pc=pc, and clears that instruction's out_regwrite.
- When undefined: no trap ports; misaligned targets redirect normally.

Test Plan:
- Reset with in_valid=1 for 3 cycles -> out_valid=0, redirect=0, in_ready=1 throughout; first beat accepted after reset drops appears 1 cycle later.
- beq pc=0x100, imm=0x20, flags=0001 -> redirect=1 for exactly one cycle, redirect_pc=0x120; next accepted beat is squashed and never appears at the output.
- blt with flags n=1,v=1 -> not taken, no redirect. bltu with c=0 -> taken. funct3=010 -> not taken.
- jalr aluresult=0x2003, pc=0x40 -> redirect_pc=0x2002, out_result=0x44. jal pc=0xFFFFFFFC, imm=8 -> redirect_pc=0x4, out_result=0x0.
- out_ready=0 with 3 back-to-back beats -> in_ready drops after 2, third held upstream, out_* stable. Releasing out_ready delivers all 3 in order with no duplicates.
- BR_MISALIGN_TRAP_EN defined, beq taken to 0x102 -> trap=1, trap_pc=pc, redirect stays 0, out_regwrite=0.
